// File: rtl/nes_pkg.sv
// nes_pkg: opcodes, sequencer states, command entry layout and register map for nes_host_bridge.
package nes_pkg;
    localparam logic [7:0] OP_RESET_CPU = 8'd0;
    localparam logic [7:0] OP_START_CPU = 8'd1;
    localparam logic [7:0] OP_PAUSE_CPU = 8'd2;
    localparam logic [7:0] OP_WRITE_MEM = 8'd3;
    localparam logic [7:0] OP_STEP_CPU  = 8'd4;
    localparam logic [1:0] REG_CMD    = 2'd0;
    localparam logic [1:0] REG_ADDR   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_SNOOP  = 2'd3;
    typedef enum logic [2:0] {
        ST_HALT     = 3'd0,
        ST_RST_HOLD = 3'd1,
        ST_PAUSED   = 3'd2,
        ST_RUN      = 3'd3,
        ST_MEMWR    = 3'd4,
        ST_STEP     = 3'd5
    } state_e;
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  op;
        logic [7:0]  data;
    } cmd_entry_t;
endpackage

// File: rtl/nes_cmd_fifo.sv
// nes_cmd_fifo: synchronous FIFO of command entries; a pop frees room for a push in the same cycle.
module nes_cmd_fifo
    import nes_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  cmd_entry_t i_din,
    input  logic       i_pop,
    output cmd_entry_t o_dout,
    output logic       o_full,
    output logic       o_empty,
    output logic [8:0] o_count
);
    localparam int AW = $clog2(DEPTH);
    cmd_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [8:0] r_count;
    logic w_wr, w_rd;
    assign w_rd = i_pop && r_count != 9'd0;
    assign w_wr = i_push && (r_count != 9'(DEPTH) || w_rd);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + 9'(w_wr) - 9'(w_rd);
        end
    end
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_din;
    end
    assign o_dout  = r_mem[r_rptr];
    assign o_full  = r_count == 9'(DEPTH);
    assign o_empty = r_count == 9'd0;
    assign o_count = r_count;
endmodule

// File: rtl/nes_host_bridge.sv
// nes_host_bridge: Avalon-MM command queue and sequencer driving NES CPU reset/ready and program memory.
// Define SINGLE_STEP_EN to enable the STEP_CPU opcode (op 4); otherwise op 4 is reported as bad_op.
module nes_host_bridge
    import nes_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int RESET_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_write,
    input  logic        cpu_sync,
    output logic        cpu_reset,
    output logic        cpu_ready,
    output logic [15:0] mem_addr,
    output logic        mem_write,
    output logic [7:0]  mem_in
);
    localparam int CW = $clog2(RESET_CYCLES + 1);
    state_e r_state, r_prior;
    logic [CW-1:0] r_rst_cnt;
    logic [15:0] r_addr, r_mem_addr, r_snoop, r_readdata;
    logic [7:0] r_mem_in;
    logic r_ovf, r_bad_op, r_step_armed;
    logic w_cmd_wr, w_addr_wr, w_stat_wr, w_pop, w_drop, w_op_ok, w_cpu_side, w_full, w_empty;
    logic [8:0] w_count;
    logic [15:0] w_status, w_rd_mux;
    cmd_entry_t w_push_entry, w_head;
    assign w_cmd_wr     = chipselect && write && address == REG_CMD;
    assign w_addr_wr    = chipselect && write && address == REG_ADDR;
    assign w_stat_wr    = chipselect && write && address == REG_STATUS;
    assign w_push_entry = {r_addr, writedata};
    assign w_pop        = !w_empty && (r_state == ST_HALT || r_state == ST_PAUSED || r_state == ST_RUN);
    assign w_drop       = w_cmd_wr && w_full && !w_pop;
    assign w_cpu_side   = r_state == ST_RUN || r_state == ST_STEP;
`ifdef SINGLE_STEP_EN
    assign w_op_ok = w_head.op <= OP_STEP_CPU;
`else
    assign w_op_ok = w_head.op <= OP_WRITE_MEM;
`endif
    nes_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .i_push (w_cmd_wr),
        .i_din  (w_push_entry),
        .i_pop  (w_pop),
        .o_dout (w_head),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_count(w_count)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_HALT;
            r_prior      <= ST_HALT;
            r_rst_cnt    <= '0;
            r_step_armed <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_in     <= '0;
        end else begin
            if (w_cpu_side) begin
                r_mem_addr <= cpu_addr;
                r_mem_in   <= cpu_dout;
            end
            r_step_armed <= 1'b1;
            case (r_state)
                ST_RST_HOLD: if (r_rst_cnt == '0) r_state <= ST_PAUSED; else r_rst_cnt <= r_rst_cnt - 1'b1;
                ST_MEMWR: r_state <= r_prior;
`ifdef SINGLE_STEP_EN
                ST_STEP: if (r_step_armed && cpu_sync) r_state <= ST_PAUSED;
`endif
                default: if (w_pop) begin
                    case (w_head.op)
                        OP_RESET_CPU: begin
                            r_state   <= ST_RST_HOLD;
                            r_rst_cnt <= CW'(RESET_CYCLES - 1);
                        end
                        OP_START_CPU: r_state <= ST_RUN;
                        OP_PAUSE_CPU: r_state <= ST_PAUSED;
                        OP_WRITE_MEM: begin
                            r_state    <= ST_MEMWR;
                            r_prior    <= r_state;
                            r_mem_addr <= w_head.addr;
                            r_mem_in   <= w_head.data;
                        end
`ifdef SINGLE_STEP_EN
                        OP_STEP_CPU: begin
                            r_state      <= ST_STEP;
                            r_step_armed <= 1'b0;
                        end
`endif
                        default: ;
                    endcase
                end
            endcase
        end
    end
    // Sticky bits: a set in the same cycle as a host clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf      <= 1'b0;
            r_bad_op   <= 1'b0;
            r_addr     <= '0;
            r_snoop    <= '0;
            r_readdata <= '0;
        end else begin
            r_ovf    <= (r_ovf && !(w_stat_wr && writedata[15])) || w_drop;
            r_bad_op <= (r_bad_op && !(w_stat_wr && writedata[14])) || (w_pop && !w_op_ok);
            if (w_addr_wr) r_addr <= writedata;
            else if (w_cmd_wr && writedata[15:8] == OP_WRITE_MEM) r_addr <= r_addr + 16'd1;
            if (cpu_sync) r_snoop <= cpu_addr;
            if (chipselect && read) r_readdata <= w_rd_mux;
        end
    end
    assign w_status = {r_ovf, r_bad_op, r_state, cpu_ready, 1'b0, w_count};
    assign w_rd_mux = address == REG_ADDR ? r_addr : address == REG_STATUS ? w_status :
                      address == REG_SNOOP ? r_snoop : 16'd0;
    assign readdata  = r_readdata;
    assign cpu_reset = r_state == ST_HALT || r_state == ST_RST_HOLD || (r_state == ST_MEMWR && r_prior == ST_HALT);
    assign cpu_ready = w_cpu_side;
    assign mem_write = w_cpu_side ? cpu_write : r_state == ST_MEMWR;
    assign mem_addr  = w_cpu_side ? cpu_addr : r_mem_addr;
    assign mem_in    = w_cpu_side ? cpu_dout : r_mem_in;
endmodule

// File: doc/nes_host_bridge.md
Name: nes_host_bridge

Overview:
Upstream of the NES core's CPU/memory pair; the HPS writes NES commands into this block over an Avalon-MM slave port. Commands are queued in a small FIFO and executed by a sequencer. The sequencer drives cpu_reset and cpu_ready, and arbitrates the single-port program memory between host loads and the running CPU. It also exposes status and CPU bus snoop registers for readback.

Parameters:
FIFO_DEPTH, 16, command FIFO entries (power of two, 2..256)
RESET_CYCLES, 8, cycles cpu_reset is held by RESET_CPU (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  2  register index: 0 CMD, 1 ADDR, 2 STATUS, 3 SNOOP
writedata  in  16  write data
readdata  out  16  registered read data
cpu_addr  in  16  CPU address bus
cpu_dout  in  8  CPU write data
cpu_write  in  1  CPU write enable
cpu_sync  in  1  CPU opcode-fetch indicator
cpu_reset  out  1  CPU reset
cpu_ready  out  1  CPU ready/run enable
mem_addr  out  16  memory address
mem_write  out  1  memory write enable
mem_in  out  8  memory write data

Behaviour:
- Opcodes: RESET_CPU=0, START_CPU=1, PAUSE_CPU=2, WRITE_MEM=3.
- CMD write (writedata[15:8]=op, [7:0]=data) pushes the entry {ADDR, op, data} into the FIFO.
- If op==WRITE_MEM, ADDR post-increments at push time; it wraps 0xFFFF->0x0000.
- ADDR write loads ADDR=writedata.
- STATUS write clears each sticky bit whose writedata bit is 1.
- Push while the FIFO is full: the entry is dropped and sticky ovf (STATUS[15]) is set.
- Pop of an unknown op: the entry is discarded, sticky bad_op (STATUS[14]) is set, and state is unchanged.
- STATUS read fields:
  - [15] ovf
  - [14] bad_op
  - [13:11] state encoding
  - [10] cpu_ready
  - [8:0] FIFO count
- SNOOP read returns {cpu_addr captured on the last cycle cpu_sync was high}[15:0].
- readdata is valid the cycle after a read with chipselect.
- FSM states:
  - HALT: reset value; cpu_reset=1, cpu_ready=0.
  - RST_HOLD: cpu_reset=1 for RESET_CYCLES cycles, then PAUSED.
  - PAUSED: cpu_reset=0, cpu_ready=0.
  - RUN: cpu_reset=0, cpu_ready=1.
  - MEMWR: one cycle; cpu_ready=0, mem_write=1, mem_addr/mem_in from the entry. Then returns to the prior state (PAUSED, RUN or HALT).
  - STEP: only with SINGLE_STEP_EN.
- The FSM pops one entry per cycle in HALT, PAUSED and RUN; it does not pop in RST_HOLD, MEMWR or STEP.
- State transitions by command:
  - RESET_CPU -> RST_HOLD from any popping state.
  - START_CPU -> RUN.
  - PAUSE_CPU -> PAUSED.
- Memory mux:
  - RUN: mem_addr=cpu_addr, mem_in=cpu_dout, mem_write=cpu_write.
  - MEMWR: host entry.
  - All other states: mem_write=0, mem_addr=last value.
- Latency: a CMD write in cycle N with the FIFO empty is popped in N+1; its effect appears on outputs in N+2.
- Reset values: cpu_reset=1, cpu_ready=0, mem_write=0, mem_addr=0, mem_in=0, readdata=0, ADDR=0, sticky bits=0, FIFO empty.
- Reset mid-MEMWR aborts the write; mem_write=0 immediately.
- A simultaneous push and pop keeps the FIFO count unchanged, including when the FIFO is full.

Optional Feature:
Macro: SINGLE_STEP_EN
- With the macro: op STEP_CPU=4 enters STEP.
  - cpu_ready=1 with the memory muxed to the CPU, as in RUN.
  - Exits to PAUSED on the first cycle after entry that has cpu_sync=1. That cycle is completed with cpu_ready=1, and cpu_ready drops the next cycle.
- Without the macro: op 4 is treated as unknown (sets bad_op).

Decomposition:
- Package nes_pkg holds:
  - opcode localparams
  - state enum
  - cmd_entry_t packed struct {addr[15:0], op[7:0], data[7:0]}
  - register index constants
- Sub-module nes_cmd_fifo: synchronous FIFO of cmd_entry_t, DEPTH param, push/pop/full/empty/count, async reset.

Test Plan:
- Reset release:
  - At reset release: cpu_reset=1, cpu_ready=0, STATUS=0x0000 (bits[13:11] read HALT's encoding, 0 under the package enum's reset value).
  - Write CMD 0x0000: cpu_reset stays 1 for exactly 8 cycles (RST_HOLD), then STATUS[13:11] reads PAUSED.
- Load sequence:
  - Write ADDR=0xFFFE, then CMD 0x03A9, then CMD 0x0385.
  - Required: mem_write pulses at 0xFFFE/0xA9 and 0xFFFF/0x85.
  - Required: ADDR reads back as wrapped to 0x0000 (a third WRITE_MEM lands at 0x0000).
- Start then pause:
  - CMD 0x0100: cpu_ready=1 two cycles after the write, and mem_addr follows cpu_addr.
  - CMD 0x0200: cpu_ready=0 and mem_write=0 even with cpu_write=1.
- WRITE_MEM while RUN:
  - cpu_ready drops for exactly 1 cycle, the host write occurs, then RUN resumes.
  - cpu_write asserted during that cycle is ignored.
- Overflow and bad op:
  - 17 back-to-back CMD writes while in RST_HOLD: STATUS[15]=1 and count=16.
  - CMD 0x7F00: STATUS[14]=1.
  - STATUS write 0xC000 clears both bits.
- SINGLE_STEP_EN:
  - CMD 0x0400 with cpu_sync high 3 cycles later: cpu_ready high for 3 cycles, state PAUSED after.
  - Without the macro: the same command sets bad_op.
